// File: rtl/traffic_light_timed_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_timed_ctrl_if
//  Description : Signal bundle between the intersection controller and its
//                surroundings (request inputs and lamp/status outputs).
//                master : drives requests, observes lamps (board/testbench)
//                slave  : the controller itself
//  Signals     : ped_req, side_sensor, night_mode        (to controller)
//                main_lights[2:0], side_lights[2:0] {R,Y,G},
//                ped_walk, ped_pending, state_o[2:0]     (from controller)
//  Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_timed_ctrl_if;
    logic       ped_req;
    logic       side_sensor;
    logic       night_mode;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] state_o;

    modport master (
        output ped_req, side_sensor, night_mode,
        input  main_lights, side_lights, ped_walk, ped_pending, state_o
    );

    modport slave (
        input  ped_req, side_sensor, night_mode,
        output main_lights, side_lights, ped_walk, ped_pending, state_o
    );
endinterface
`default_nettype wire

// File: rtl/traffic_light_timed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_timed_ctrl
//  Description : Self-timed two-street intersection controller with a
//                pedestrian phase, demand-driven side/ped phase skipping and
//                a night flashing mode. An internal prescaler produces a
//                one-cycle tick every TICK_DIV clocks; each phase dwells a
//                parameterised number of ticks.
//  Ports       : clk      - single clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - traffic_light_timed_ctrl_if.slave
//                           in : ped_req, side_sensor, night_mode
//                           out: main_lights, side_lights, ped_walk,
//                                ped_pending, state_o
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_timed_ctrl #(
    parameter int TICK_DIV         = 1000,
    parameter int GREEN_TICKS      = 20,
    parameter int SIDE_GREEN_TICKS = 10,
    parameter int YELLOW_TICKS     = 4,
    parameter int ALLRED_TICKS     = 2,
    parameter int PED_TICKS        = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    traffic_light_timed_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_GR    = 3'd0,
        S_YR    = 3'd1,
        S_RR1   = 3'd2,
        S_RG    = 3'd3,
        S_RY    = 3'd4,
        S_RR2   = 3'd5,
        S_PED   = 3'd6,
        S_FLASH = 3'd7
    } state_t;

    // Counter sizing: just wide enough for the largest value ever held.
    localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_MAX_A   = (GREEN_TICKS > SIDE_GREEN_TICKS) ? GREEN_TICKS : SIDE_GREEN_TICKS;
    localparam int c_MAX_B   = (YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS;
    localparam int c_MAX_C   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_MAX_DUR = (c_MAX_C > PED_TICKS) ? c_MAX_C : PED_TICKS;
    localparam int c_DWELL_W = (c_MAX_DUR > 1) ? $clog2(c_MAX_DUR) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_LOAD_GR    = c_DWELL_W'(GREEN_TICKS - 1);
    localparam logic [c_DWELL_W-1:0] c_LOAD_RG    = c_DWELL_W'(SIDE_GREEN_TICKS - 1);
    localparam logic [c_DWELL_W-1:0] c_LOAD_YEL   = c_DWELL_W'(YELLOW_TICKS - 1);
    localparam logic [c_DWELL_W-1:0] c_LOAD_RED   = c_DWELL_W'(ALLRED_TICKS - 1);
    localparam logic [c_DWELL_W-1:0] c_LOAD_PED   = c_DWELL_W'(PED_TICKS - 1);

    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_YELLOW = 3'b010;
    localparam logic [2:0] c_GREEN  = 3'b001;

    state_t                 r_state;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [c_DWELL_W-1:0]   r_dwell;
    logic                   r_flash;
    logic                   r_pedPending;
    logic                   r_sidePending;
    logic [2:0]             r_mainLights;
    logic [2:0]             r_sideLights;
    logic                   r_pedWalk;

    state_t                 w_stateNext;
    logic                   w_tick;
    logic                   w_expired;
    logic                   w_stateChange;
    logic [c_PRESC_W-1:0]   w_prescNext;
    logic [c_DWELL_W-1:0]   w_dwellNext;
    logic                   w_flashNext;
    logic                   w_pedPendingNext;
    logic                   w_sidePendingNext;
    logic [2:0]             w_mainLights;
    logic [2:0]             w_sideLights;
    logic                   w_pedWalk;

    assign w_tick        = (r_presc == c_PRESC_LAST);
    assign w_expired     = w_tick && (r_dwell == '0);
    assign w_stateChange = (w_stateNext != r_state);

    // Next-state, counters, latches and lamp decode.
    always_comb begin
        w_stateNext       = r_state;
        w_prescNext       = r_presc;
        w_dwellNext       = r_dwell;
        w_flashNext       = r_flash;
        w_pedPendingNext  = r_pedPending | bus.ped_req;
        w_sidePendingNext = r_sidePending | bus.side_sensor;
        w_mainLights      = c_RED;
        w_sideLights      = c_RED;
        w_pedWalk         = 1'b0;

        case (r_state)
            S_GR: begin
                // Green extends indefinitely until some demand shows up.
                if (w_expired && (r_sidePending || r_pedPending || bus.night_mode))
                    w_stateNext = S_YR;
            end
            S_YR:  if (w_expired) w_stateNext = S_RR1;
            S_RR1: begin
                if (w_expired)
                    w_stateNext = (r_sidePending && !bus.night_mode) ? S_RG : S_RR2;
            end
            S_RG:  if (w_expired) w_stateNext = S_RY;
            S_RY:  if (w_expired) w_stateNext = S_RR2;
            S_RR2: begin
                if (w_expired) begin
                    if (bus.night_mode)
                        w_stateNext = S_FLASH;
                    else if (r_pedPending)
                        w_stateNext = S_PED;
                    else
                        w_stateNext = S_GR;
                end
            end
            S_PED: if (w_expired) w_stateNext = S_GR;
            S_FLASH: begin
                // Dwell counter is ignored here; only the tick matters.
                if (w_tick && !bus.night_mode)
                    w_stateNext = S_RR2;
            end
            default: w_stateNext = S_RR2;
        endcase

        // Prescaler restarts on every state change so dwell is exact.
        if (w_stateChange || w_tick)
            w_prescNext = '0;
        else
            w_prescNext = r_presc + 1'b1;

        if (w_stateChange) begin
            case (w_stateNext)
                S_GR:          w_dwellNext = c_LOAD_GR;
                S_YR, S_RY:    w_dwellNext = c_LOAD_YEL;
                S_RG:          w_dwellNext = c_LOAD_RG;
                S_PED:         w_dwellNext = c_LOAD_PED;
                default:       w_dwellNext = c_LOAD_RED;
            endcase
        end else if (w_tick && (r_dwell != '0)) begin
            w_dwellNext = r_dwell - 1'b1;
        end

        if (w_stateChange && (w_stateNext == S_FLASH))
            w_flashNext = 1'b1;
        else if ((r_state == S_FLASH) && w_tick)
            w_flashNext = ~r_flash;

        // Walk phase swallows requests, including those arriving on its
        // entry cycle and on its exit cycle.
        if ((w_stateNext == S_PED) || (r_state == S_PED))
            w_pedPendingNext = 1'b0;

        if (w_stateChange && (w_stateNext == S_RG))
            w_sidePendingNext = 1'b0;

        // Lamps are decoded from the upcoming state so they register
        // together with the state itself.
        case (w_stateNext)
            S_GR:    w_mainLights = c_GREEN;
            S_YR:    w_mainLights = c_YELLOW;
            S_RG:    w_sideLights = c_GREEN;
            S_RY:    w_sideLights = c_YELLOW;
            S_PED:   w_pedWalk    = 1'b1;
            S_FLASH: begin
                w_mainLights = {1'b0, w_flashNext, 1'b0};
                w_sideLights = {w_flashNext, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_RR2;
            r_presc       <= '0;
            r_dwell       <= c_LOAD_RED;
            r_flash       <= 1'b0;
            r_pedPending  <= 1'b0;
            r_sidePending <= 1'b0;
            r_mainLights  <= c_RED;
            r_sideLights  <= c_RED;
            r_pedWalk     <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_presc       <= w_prescNext;
            r_dwell       <= w_dwellNext;
            r_flash       <= w_flashNext;
            r_pedPending  <= w_pedPendingNext;
            r_sidePending <= w_sidePendingNext;
            r_mainLights  <= w_mainLights;
            r_sideLights  <= w_sideLights;
            r_pedWalk     <= w_pedWalk;
        end
    end

    assign bus.main_lights = r_mainLights;
    assign bus.side_lights = r_sideLights;
    assign bus.ped_walk    = r_pedWalk;
    assign bus.ped_pending = r_pedPending;
    assign bus.state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_timed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_timed_ctrl
//  Description : Directed self-checking bench for traffic_light_timed_ctrl
//                with TICK_DIV=4, GREEN=5, SIDE_GREEN=3, YELLOW=2,
//                ALLRED=1, PED=3 (tick = 4 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_timed_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    traffic_light_timed_ctrl_if bus ();

    traffic_light_timed_ctrl #(
        .TICK_DIV         (4),
        .GREEN_TICKS      (5),
        .SIDE_GREEN_TICKS (3),
        .YELLOW_TICKS     (2),
        .ALLRED_TICKS     (1),
        .PED_TICKS        (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the first negedge of a phase (pre = cycles already spent in
    // it before this call); checks lamps now and the phase length in cycles.
    task automatic phase(input string tag, input logic [2:0] st, input int pre, input int expCyc,
                         input logic [2:0] expMain, input logic [2:0] expSide, input logic expWalk);
        int cnt;
        check({tag, "_state"}, 32'(bus.state_o), 32'(st));
        check({tag, "_main"},  32'(bus.main_lights), 32'(expMain));
        check({tag, "_side"},  32'(bus.side_lights), 32'(expSide));
        check({tag, "_walk"},  32'(bus.ped_walk), 32'(expWalk));
        cnt = pre + 1;
        while (cnt < 1000) begin
            @(negedge clk);
            if (bus.state_o !== st) break;
            cnt++;
        end
        check({tag, "_len"}, 32'(cnt), 32'(expCyc));
    endtask

    task automatic wait_change(output int n);
        logic [2:0] s0;
        s0 = bus.state_o;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.state_o === s0) && (n < 100));
    endtask

    // Safety invariant every cycle: no two streets showing G/Y, and walk
    // only with both streets red.
    always @(negedge clk) begin
        total++;
        assert (!((|bus.main_lights[1:0]) && (|bus.side_lights[1:0])) &&
                !(bus.ped_walk && !(bus.main_lights == 3'b100 && bus.side_lights == 3'b100)))
        else begin
            bad++;
            $error("FAIL safety observed main=%b side=%b walk=%b expected safe lamps",
                   bus.main_lights, bus.side_lights, bus.ped_walk);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.ped_req = 1'b0;
        bus.side_sensor = 1'b0;
        bus.night_mode = 1'b0;

        // ---- reset values
        repeat (3) @(negedge clk);
        check("rst_state", 32'(bus.state_o), 32'd5);
        check("rst_main", 32'(bus.main_lights), 32'b100);
        check("rst_side", 32'(bus.side_lights), 32'b100);
        check("rst_walk", 32'(bus.ped_walk), 32'd0);
        check("rst_pend", 32'(bus.ped_pending), 32'd0);

        // ---- release: RR2 for 4 cycles, then GR held with no demand
        reset_n = 1'b1;
        phase("boot_rr2", 3'd5, 0, 4, 3'b100, 3'b100, 1'b0);
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.state_o === 3'd0 && bus.main_lights === 3'b001 && bus.side_lights === 3'b100) n++;
        end
        check("gr_hold200", 32'(n), 32'd200);

        // ---- side demand after minimum green: exit on next tick
        bus.side_sensor = 1'b1;
        wait_change(n);
        bus.side_sensor = 1'b0;
        check("side_exit_wait", 32'(n), 32'd4);
        phase("s_yr",  3'd1, 0, 8,  3'b010, 3'b100, 1'b0);
        phase("s_rr1", 3'd2, 0, 4,  3'b100, 3'b100, 1'b0);
        phase("s_rg",  3'd3, 0, 12, 3'b100, 3'b001, 1'b0);
        phase("s_ry",  3'd4, 0, 8,  3'b100, 3'b010, 1'b0);
        phase("s_rr2", 3'd5, 0, 4,  3'b100, 3'b100, 1'b0);

        // ---- single pedestrian pulse: side phase skipped
        check("p_pend_before", 32'(bus.ped_pending), 32'd0);
        bus.ped_req = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
        check("p_pend_latency", 32'(bus.ped_pending), 32'd1);
        phase("p_gr",  3'd0, 1, 20, 3'b001, 3'b100, 1'b0);
        phase("p_yr",  3'd1, 0, 8,  3'b010, 3'b100, 1'b0);
        phase("p_rr1", 3'd2, 0, 4,  3'b100, 3'b100, 1'b0);
        phase("p_rr2", 3'd5, 0, 4,  3'b100, 3'b100, 1'b0);
        check("p_pend_ped", 32'(bus.ped_pending), 32'd0);
        phase("p_ped", 3'd6, 0, 12, 3'b100, 3'b100, 1'b1);

        // ---- pedestrian button held through the walk phase
        bus.ped_req = 1'b1;
        @(negedge clk);
        phase("h_gr",  3'd0, 1, 20, 3'b001, 3'b100, 1'b0);
        phase("h_yr",  3'd1, 0, 8,  3'b010, 3'b100, 1'b0);
        phase("h_rr1", 3'd2, 0, 4,  3'b100, 3'b100, 1'b0);
        phase("h_rr2", 3'd5, 0, 4,  3'b100, 3'b100, 1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.state_o === 3'd6 && bus.ped_pending === 1'b0 && bus.ped_walk === 1'b1) n++;
            @(negedge clk);
        end
        check("h_ped_pend0", 32'(n), 32'd12);
        check("h_exit_state", 32'(bus.state_o), 32'd0);
        check("h_exit_pend", 32'(bus.ped_pending), 32'd0);
        @(negedge clk);
        check("h_reassert", 32'(bus.ped_pending), 32'd1);

        // ---- night mode with a pending pedestrian request
        bus.ped_req = 1'b0;
        bus.night_mode = 1'b1;
        phase("n_gr",  3'd0, 1, 20, 3'b001, 3'b100, 1'b0);
        phase("n_yr",  3'd1, 0, 8,  3'b010, 3'b100, 1'b0);
        phase("n_rr1", 3'd2, 0, 4,  3'b100, 3'b100, 1'b0);
        phase("n_rr2", 3'd5, 0, 4,  3'b100, 3'b100, 1'b0);
        check("f_state", 32'(bus.state_o), 32'd7);
        check("f_main1", 32'(bus.main_lights), 32'b010);
        check("f_side1", 32'(bus.side_lights), 32'b100);
        check("f_pend", 32'(bus.ped_pending), 32'd1);
        repeat (3) @(negedge clk);
        check("f_main4", 32'(bus.main_lights), 32'b010);
        @(negedge clk);
        check("f_main5", 32'(bus.main_lights), 32'b000);
        check("f_side5", 32'(bus.side_lights), 32'b000);
        repeat (3) @(negedge clk);
        check("f_main8", 32'(bus.main_lights), 32'b000);
        @(negedge clk);
        check("f_main9", 32'(bus.main_lights), 32'b010);
        bus.night_mode = 1'b0;
        wait_change(n);
        check("f_exit_wait", 32'(n), 32'd4);
        check("f_exit_pend", 32'(bus.ped_pending), 32'd1);
        phase("f_rr2", 3'd5, 0, 4,  3'b100, 3'b100, 1'b0);
        phase("f_ped", 3'd6, 0, 12, 3'b100, 3'b100, 1'b1);

        // ---- reset mid side-green with both latches set
        bus.side_sensor = 1'b1;
        @(negedge clk);
        bus.side_sensor = 1'b0;
        phase("r_gr",  3'd0, 1, 20, 3'b001, 3'b100, 1'b0);
        phase("r_yr",  3'd1, 0, 8,  3'b010, 3'b100, 1'b0);
        phase("r_rr1", 3'd2, 0, 4,  3'b100, 3'b100, 1'b0);
        check("r_rg_state", 32'(bus.state_o), 32'd3);
        bus.ped_req = 1'b1;
        bus.side_sensor = 1'b1;
        @(negedge clk);
        bus.ped_req = 1'b0;
        bus.side_sensor = 1'b0;
        check("r_pend_set", 32'(bus.ped_pending), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ar_state", 32'(bus.state_o), 32'd5);
        check("ar_main", 32'(bus.main_lights), 32'b100);
        check("ar_side", 32'(bus.side_lights), 32'b100);
        check("ar_walk", 32'(bus.ped_walk), 32'd0);
        check("ar_pend", 32'(bus.ped_pending), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        phase("ar_rr2", 3'd5, 0, 4, 3'b100, 3'b100, 1'b0);
        // A surviving side latch would end green after 20 cycles.
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.state_o === 3'd0) n++;
        end
        check("ar_gr_hold", 32'(n), 32'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_timed_ctrl.md
# traffic_light_timed_ctrl

Parametrised, self-timed two-street intersection controller with a pedestrian phase. It replaces the externally stepped light sequencer with an internal tick prescaler, per-phase dwell counters and demand-driven phase skipping. It also adds a night flashing mode. The block sits between the board clock/reset and the lamp drivers; request inputs arrive already synchronised to `clk`.

## Interface
- `TICK_DIV`, default 1000: `clk` cycles per tick, ≥1.
- `GREEN_TICKS`, default 20: minimum main-green dwell, ≥1.
- `SIDE_GREEN_TICKS`, default 10: side-green dwell, ≥1.
- `YELLOW_TICKS`, default 4: yellow dwell on either street, ≥1.
- `ALLRED_TICKS`, default 2: all-red clearance dwell, ≥1.
- `PED_TICKS`, default 8: walk dwell, ≥1.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ped_req`  in  1  pedestrian button, level; any high cycle registers a request.
- `side_sensor`  in  1  side-street vehicle present, level; any high cycle registers demand.
- `night_mode`  in  1  level; requests flashing operation.
- `main_lights`  out  3  {R,Y,G}, one-hot except in FLASH.
- `side_lights`  out  3  {R,Y,G}, one-hot except in FLASH.
- `ped_walk`  out  1  high only in PED.
- `ped_pending`  out  1  registered pedestrian request.
- `state_o`  out  3  current state code.

## Operation
- State codes: GR=0, YR=1, RR1=2, RG=3, RY=4, RR2=5, PED=6, FLASH=7.
- Lamps (main/side):
  - GR: G/R.
  - YR: Y/R.
  - RR1 and RR2: R/R.
  - RG: R/G.
  - RY: R/Y.
  - PED: R/R with `ped_walk`=1.
  - FLASH: main={0,flash,0}, side={flash,0,0}.
- Reset value: state RR2, `main_lights`=`side_lights`=3'b100, `ped_walk`=0, `ped_pending`=0, `side_pending`=0, prescaler=0, dwell counter=ALLRED_TICKS-1.
- Prescaler: counts 0..TICK_DIV-1 and asserts an internal one-cycle `tick` at TICK_DIV-1. It is cleared on every state change.
- Dwell counter: loaded with DUR-1 on state entry and decremented on each `tick` until it reaches 0. A state is "expired" when the counter is 0 and `tick`=1.
- Pending latches:
  - `ped_pending` <= (`ped_pending` | `ped_req`), cleared on entry to PED and held 0 while in PED. Requests during PED are ignored.
  - `side_pending` is the same, driven by `side_sensor`, and is cleared on entry to RG.
- Transitions, evaluated only when expired:
  - GR→YR if `side_pending` | `ped_pending` | `night_mode`. Otherwise stay in GR: green extends and is re-evaluated every tick.
  - YR→RR1.
  - RR1→RG if `side_pending` & !`night_mode`, else RR1→RR2 (side phase skipped).
  - RG→RY, RY→RR2.
  - RR2 priority order: FLASH if `night_mode`; else PED if `ped_pending`; else GR.
  - PED→GR.
  - FLASH: `flash` is 1 on entry and toggles each tick. Exit to RR2 on the first tick with `night_mode`=0. The dwell counter is unused in FLASH.
- Dwell per state: GR ≥GREEN_TICKS, YR/RY YELLOW_TICKS, RR1/RR2 ALLRED_TICKS, RG SIDE_GREEN_TICKS, PED PED_TICKS.
- Widths: each counter is `$clog2` of its maximum + 1, minimum 1 bit. No arithmetic wrap: the counter holds at 0 while GR extends.
- Safety invariant: never both streets non-red, and `ped_walk` is never high unless both are red.

## Timing
- All outputs are registered and decoded from state. They change in the cycle after the state-changing edge's decode, so lamps and `state_o` update together.
- Exact dwell in cycles is DUR×TICK_DIV, because the prescaler restarts on entry.
- A request becomes visible on `ped_pending` one cycle after `ped_req` is sampled high.
- Simultaneous events:
  - A request in the PED-entry cycle is absorbed by that PED phase.
  - `night_mode` together with `ped_pending` in RR2 → FLASH. The pedestrian request stays pending and is served at the RR2 after FLASH exits.
- Reset assertion at any time forces reset values asynchronously. After release, the first GR is entered ALLRED_TICKS×TICK_DIV cycles later.

## Test plan
All scenarios use TICK_DIV=4, GREEN=5, SIDE_GREEN=3, YELLOW=2, ALLRED=1, PED=3.

- Reset release, no inputs → `state_o`=5 for 4 cycles, then 0, and stays 0 for ≥200 cycles with `main_lights`=3'b001, `side_lights`=3'b100.
- One-cycle `side_sensor` pulse during GR after minimum → GR exits on the next tick. Sequence YR 8 cycles, RR1 4, RG 12, RY 8, RR2 4, GR. `side_pending` drops on RG entry.
- One-cycle `ped_req` only → GR→YR→RR1→RR2 (RG skipped)→PED with `ped_walk`=1 for 12 cycles →GR. `ped_pending` drops on PED entry.
- `ped_req` held high through PED → `ped_pending` stays 0 during PED and re-asserts 1 cycle after PED exit.
- `night_mode`=1 with `ped_pending`=1 → RR2→FLASH. Main toggles 3'b010/3'b000 every 4 cycles, starting 3'b010. After `night_mode`=0: RR2→PED→GR.
- `reset_n` low mid-RG → outputs immediately 3'b100/3'b100, `state_o`=5, both pending flags 0. The safety invariant is checked every cycle in all tests.
